// File: rtl/led_pkg.sv
// Shared definitions for the LED display blocks: column geometry, commit FSM
// encoding and the default frame counter width.
package led_pkg;

  localparam int NUM_COLS  = 4;
  localparam int COL_W     = 8;
  localparam int COL_IDX_W = 2;
  localparam int FCW_DEF   = 8;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } commit_state_t;

  // Index width for an N-entry selector; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first valid requester at or after ptr
// (wrapping modulo N) receives a one-hot grant and its index.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] gidx
);

  logic          found;
  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int off = 0; off < N; off++) begin
      // One spare bit so ptr+off can exceed N-1 before the wrap.
      sum = {1'b0, ptr} + (PW+1)'(off);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      idx = sum[PW-1:0];
      if (!found && valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = idx;
      end
    end
  end

endmodule

// File: rtl/led_frame_scheduler.sv
// Shares the 4x8 LED video memory between NREQ writers and swaps the back
// buffer into the displayed front buffer only on a frame boundary.
module led_frame_scheduler
  import led_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int FCW  = FCW_DEF
) (
  input  logic                      clk12MHz,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [COL_IDX_W*NREQ-1:0] req_col,
  input  logic [COL_W*NREQ-1:0]     req_data,
  output logic [NREQ-1:0]           req_ready,
  input  logic                      commit,
  input  logic                      frame_sync,
  output logic                      commit_pending,
  output logic [FCW-1:0]            frame_count,
  output logic [COL_W-1:0]          leds1,
  output logic [COL_W-1:0]          leds2,
  output logic [COL_W-1:0]          leds3,
  output logic [COL_W-1:0]          leds4
);

  localparam int PW = idx_width(NREQ);

  logic [PW-1:0]        rr_ptr;
  logic [NREQ-1:0]      grant;
  logic [PW-1:0]        gidx;
  logic                 wr_en;
  logic [COL_IDX_W-1:0] wr_col;
  logic [COL_W-1:0]     wr_data;
  commit_state_t        state;

  logic [COL_W-1:0] back  [NUM_COLS];
  logic [COL_W-1:0] front [NUM_COLS];

  rr_arbiter #(.N(NREQ)) u_arb (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .gidx  (gidx)
  );

  // Grant is combinational; held low while reset is asserted.
  assign req_ready = rst ? '0 : grant;
  assign wr_en     = |req_ready;

  always_comb begin
    wr_col  = '0;
    wr_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        wr_col  = req_col[i*COL_IDX_W +: COL_IDX_W];
        wr_data = req_data[i*COL_W +: COL_W];
      end
    end
  end

  always_ff @(posedge clk12MHz or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (wr_en) begin
      rr_ptr <= (gidx == PW'(NREQ-1)) ? '0 : gidx + 1'b1;
    end
  end

  always_ff @(posedge clk12MHz or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_COLS; k++) back[k] <= '0;
    end else if (wr_en) begin
      back[wr_col] <= wr_data;
    end
  end

  // Commit FSM: a swap copies the pre-edge back buffer, so a write landing on
  // the same edge stays in back only until the next commit.
  always_ff @(posedge clk12MHz or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      commit_pending <= 1'b0;
      frame_count    <= '0;
      for (int k = 0; k < NUM_COLS; k++) front[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (commit) begin
            state          <= PENDING;
            commit_pending <= 1'b1;
          end
        end
        PENDING: begin
          if (frame_sync) begin
            state          <= IDLE;
            commit_pending <= 1'b0;
            frame_count    <= frame_count + 1'b1;
            for (int k = 0; k < NUM_COLS; k++) front[k] <= back[k];
          end
        end
        default: begin
          state          <= IDLE;
          commit_pending <= 1'b0;
        end
      endcase
    end
  end

  assign leds1 = front[0];
  assign leds2 = front[1];
  assign leds3 = front[2];
  assign leds4 = front[3];

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Directed-vector bench for led_frame_scheduler with NREQ=2 and FCW=8.
module tb_led_frame_scheduler;

  logic        clk12MHz;
  logic        rst;
  logic [1:0]  req_valid;
  logic [3:0]  req_col;
  logic [15:0] req_data;
  logic [1:0]  req_ready;
  logic        commit;
  logic        frame_sync;
  logic        commit_pending;
  logic [7:0]  frame_count;
  logic [7:0]  leds1, leds2, leds3, leds4;

  int tests;
  int fails;

  led_frame_scheduler #(.NREQ(2), .FCW(8)) dut (
    .clk12MHz       (clk12MHz),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_col        (req_col),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .commit         (commit),
    .frame_sync     (frame_sync),
    .commit_pending (commit_pending),
    .frame_count    (frame_count),
    .leds1          (leds1),
    .leds2          (leds2),
    .leds3          (leds3),
    .leds4          (leds4)
  );

  initial clk12MHz = 1'b0;
  always #42 clk12MHz = ~clk12MHz;

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk12MHz);
    #1;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  task automatic pulse_sync();
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    req_valid = '0;
    req_col = '0;
    req_data = '0;
    commit = 1'b0;
    frame_sync = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    check("rst_leds1", leds1, 8'h00);
    check("rst_fc", frame_count, 8'h00);
    check("rst_pending", commit_pending, 1'b0);
    check("idle_ready", req_ready, 2'b00);

    // Single write col2=A5 from req0, commit, frame_sync five cycles later.
    req_valid = 2'b01; req_col = 4'b0010; req_data = 16'h00A5;
    #1 check("w1_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    check("w1_leds3_before", leds3, 8'h00);
    pulse_commit();
    check("w1_pending_c1", commit_pending, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("w1_pending_wait", commit_pending, 1'b1);
      check("w1_leds3_wait", leds3, 8'h00);
    end
    pulse_sync();
    check("w1_leds3_after", leds3, 8'hA5);
    check("w1_fc", frame_count, 8'h01);
    check("w1_pending_clr", commit_pending, 1'b0);

    // Round robin: rr_ptr=1 after req0's write, so grants go 1,0,1,0.
    req_valid = 2'b11; req_col = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      req_data = {8'h20 + 8'(i), 8'h10 + 8'(i)};
      #1 check("rr_grant", req_ready, (i % 2 == 0) ? 2'b10 : 2'b01);
      tick();
    end
    req_valid = 2'b00;
    #1 check("rr_novalid", req_ready, 2'b00);
    pulse_commit();
    pulse_sync();
    check("rr_leds1", leds1, 8'h13);
    check("rr_leds2", leds2, 8'h22);
    check("rr_fc", frame_count, 8'h02);

    // commit and frame_sync together in IDLE: swap waits for the next sync.
    req_valid = 2'b10; req_col = 4'b0000; req_data = 16'h3C00;
    #1 check("sc_ready", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    commit = 1'b1; frame_sync = 1'b1;
    tick();
    commit = 1'b0; frame_sync = 1'b0;
    check("sc_leds1_hold", leds1, 8'h13);
    check("sc_pending", commit_pending, 1'b1);
    check("sc_fc_hold", frame_count, 8'h02);
    tick();
    pulse_sync();
    check("sc_leds1", leds1, 8'h3C);
    check("sc_fc", frame_count, 8'h03);

    // Write col1 colliding with the swap: front takes the old 0x11.
    req_valid = 2'b01; req_col = 4'b0001; req_data = 16'h0011;
    tick();
    req_valid = 2'b00;
    pulse_commit();
    req_valid = 2'b01; req_col = 4'b0001; req_data = 16'h00FF;
    frame_sync = 1'b1;
    #1 check("col_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00; frame_sync = 1'b0;
    check("col_leds2_old", leds2, 8'h11);
    check("col_fc", frame_count, 8'h04);
    pulse_commit();
    pulse_sync();
    check("col_leds2_new", leds2, 8'hFF);
    check("col_fc2", frame_count, 8'h05);

    // Three commits coalesce into one swap.
    pulse_commit();
    pulse_commit();
    pulse_commit();
    check("coal_pending", commit_pending, 1'b1);
    check("coal_fc_hold", frame_count, 8'h05);
    pulse_sync();
    check("coal_fc", frame_count, 8'h06);
    check("coal_pending_clr", commit_pending, 1'b0);

    // commit with frame_sync while PENDING: swap happens, new commit dropped.
    pulse_commit();
    commit = 1'b1; frame_sync = 1'b1;
    tick();
    commit = 1'b0; frame_sync = 1'b0;
    check("drop_pending", commit_pending, 1'b0);
    check("drop_fc", frame_count, 8'h07);

    // Frame counter wrap.
    for (int i = 0; i < 248; i++) begin
      pulse_commit();
      pulse_sync();
    end
    check("wrap_fc_ff", frame_count, 8'hFF);
    pulse_commit();
    pulse_sync();
    check("wrap_fc_00", frame_count, 8'h00);

    // Asynchronous reset mid-stream with a queued commit and a live request.
    req_valid = 2'b01; req_col = 4'b0011; req_data = 16'h0077;
    tick();
    pulse_commit();
    req_valid = 2'b11;
    #20 rst = 1'b1;
    #1;
    check("arst_leds1", leds1, 8'h00);
    check("arst_leds2", leds2, 8'h00);
    check("arst_leds3", leds3, 8'h00);
    check("arst_leds4", leds4, 8'h00);
    check("arst_fc", frame_count, 8'h00);
    check("arst_pending", commit_pending, 1'b0);
    check("arst_ready", req_ready, 2'b00);
    req_valid = 2'b00;
    tick();
    rst = 1'b0;
    tick();
    pulse_sync();
    check("arst_no_swap_fc", frame_count, 8'h00);
    check("arst_no_swap_pend", commit_pending, 1'b0);
    pulse_commit();
    pulse_sync();
    check("arst_back_clr", leds4, 8'h00);
    check("arst_fc_after", frame_count, 8'h01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
